// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Optional lap capture is enabled with the STOPWATCH_LAP_EN macro (see stopwatch_ctrl).
package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 7;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    // True when the next tick would push the display past max_min:59.
    function automatic logic sat_pending(
        input logic [MIN_W-1:0] min_v,
        input logic [MIN_W-1:0] min_max,
        input logic [SEC_W-1:0] sec_v
    );
        return (min_v == min_max) && (sec_v == SEC_MAX);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler for the stopwatch. Counts 0..CLK_DIV-1 while run is
// high; zero forces the count back to 0, hold freezes it (zero wins over hold).
// tc flags the terminal count so the controller can qualify its tick.
module tick_gen #(
    parameter int CLK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic hold,
    input  logic zero,
    output logic tc
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next prescaler value: clear, freeze, count with wrap, or idle-hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (zero) begin
            cnt_nxt_s = '0;
        end else if (hold) begin
            cnt_nxt_s = cnt_r;
        end else if (run) begin
            if (cnt_r == TC_VAL) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + 1'b1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: IDLE/RUN/PAUSE/DONE state machine, seconds
// counter enable/clear, minutes count with saturation at MAX_MIN:59.
// Defining STOPWATCH_LAP_EN adds lap capture ports (lap, lap_min, lap_sec, lap_valid).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 100_000_000,
    parameter int MAX_MIN = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             sec_rollover,
    input  logic [SEC_W-1:0] sec_value,
    output logic             sec_en,
    output logic             sec_clr,
    output logic [MIN_W-1:0] minutes,
    output logic [1:0]       state,
    output logic             running,
    output logic             overflow
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic             lap,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec,
    output logic             lap_valid
`endif
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    sw_state_t        state_r;
    sw_state_t        state_nxt_s;
    logic             sec_en_r;
    logic             sec_en_nxt_s;
    logic             sec_clr_r;
    logic             sec_clr_nxt_s;
    logic [MIN_W-1:0] minutes_r;
    logic [MIN_W-1:0] minutes_nxt_s;
    logic             running_r;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             tc_s;
    logic             in_run_s;
    logic             tick_s;
    logic             sat_s;
    logic             pre_zero_s;
    logic             pre_hold_s;

    assign in_run_s = (state_r == ST_RUN);
    assign tick_s   = in_run_s && tc_s;
    assign sat_s    = sat_pending(minutes_r, MAX_MIN_V, sec_value);

    // A stop in RUN freezes the prescaler so a tick swallowed by the stop is
    // delivered right after resume; clear and a fresh start restart the second.
    assign pre_zero_s = clear || ((state_r == ST_IDLE) && start);
    assign pre_hold_s = in_run_s && stop;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (in_run_s),
        .hold  (pre_hold_s),
        .zero  (pre_zero_s),
        .tc    (tc_s)
    );

    // Next state and one-cycle pulses; priority clear > stop > start > tick.
    always_comb begin
        state_nxt_s    = state_r;
        sec_en_nxt_s   = 1'b0;
        sec_clr_nxt_s  = 1'b0;
        overflow_nxt_s = overflow_r;
        if (clear) begin
            state_nxt_s    = ST_IDLE;
            sec_clr_nxt_s  = 1'b1;
            overflow_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (tick_s) begin
                        if (sat_s) begin
                            state_nxt_s    = ST_DONE;
                            overflow_nxt_s = 1'b1;
                        end else begin
                            sec_en_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Minutes advance on each seconds wrap and stick at MAX_MIN.
    always_comb begin
        minutes_nxt_s = minutes_r;
        if (clear) begin
            minutes_nxt_s = '0;
        end else if (sec_rollover && (minutes_r < MAX_MIN_V)) begin
            minutes_nxt_s = minutes_r + 1'b1;
        end else begin
            minutes_nxt_s = minutes_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sec_en_r   <= 1'b0;
            sec_clr_r  <= 1'b0;
            minutes_r  <= '0;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sec_en_r   <= sec_en_nxt_s;
            sec_clr_r  <= sec_clr_nxt_s;
            minutes_r  <= minutes_nxt_s;
            running_r  <= (state_nxt_s == ST_RUN);
            overflow_r <= overflow_nxt_s;
        end
    end

    assign sec_en   = sec_en_r;
    assign sec_clr  = sec_clr_r;
    assign minutes  = minutes_r;
    assign state    = state_r;
    assign running  = running_r;
    assign overflow = overflow_r;

`ifdef STOPWATCH_LAP_EN
    logic [MIN_W-1:0] lap_min_r;
    logic [SEC_W-1:0] lap_sec_r;
    logic             lap_valid_r;

    // Lap snapshot: taken only while running, wiped by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_min_r   <= '0;
            lap_sec_r   <= '0;
            lap_valid_r <= 1'b0;
        end else if (clear) begin
            lap_min_r   <= '0;
            lap_sec_r   <= '0;
            lap_valid_r <= 1'b0;
        end else if (lap && in_run_s) begin
            lap_min_r   <= minutes_r;
            lap_sec_r   <= sec_value;
            lap_valid_r <= 1'b1;
        end else begin
            lap_min_r   <= lap_min_r;
            lap_sec_r   <= lap_sec_r;
            lap_valid_r <= lap_valid_r;
        end
    end

    assign lap_min   = lap_min_r;
    assign lap_sec   = lap_sec_r;
    assign lap_valid = lap_valid_r;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4 and a seconds counter model.
// A second instance with MAX_MIN=1 covers saturation. Lap checks compile in
// only when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance (MAX_MIN default)
    logic       start, stop, clear;
    logic       sec_en, sec_clr, running, overflow;
    logic [6:0] minutes;
    logic [1:0] state;
    logic [5:0] sec_value;
    logic       sec_rollover;

    // Saturation instance (MAX_MIN=1)
    logic       s_start, s_stop, s_clear;
    logic       s_sec_en, s_sec_clr, s_running, s_overflow;
    logic [6:0] s_minutes;
    logic [1:0] s_state;
    logic [5:0] s_sec_value;
    logic       s_sec_rollover;

`ifdef STOPWATCH_LAP_EN
    logic       lap, s_lap;
    logic [6:0] lap_min, s_lap_min;
    logic [5:0] lap_sec, s_lap_sec;
    logic       lap_valid, s_lap_valid;
`endif

    stopwatch_ctrl #(.CLK_DIV(4), .MAX_MIN(99)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .sec_rollover(sec_rollover), .sec_value(sec_value),
        .sec_en(sec_en), .sec_clr(sec_clr), .minutes(minutes), .state(state),
        .running(running), .overflow(overflow)
`ifdef STOPWATCH_LAP_EN
        , .lap(lap), .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid)
`endif
    );

    stopwatch_ctrl #(.CLK_DIV(4), .MAX_MIN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .clear(s_clear),
        .sec_rollover(s_sec_rollover), .sec_value(s_sec_value),
        .sec_en(s_sec_en), .sec_clr(s_sec_clr), .minutes(s_minutes), .state(s_state),
        .running(s_running), .overflow(s_overflow)
`ifdef STOPWATCH_LAP_EN
        , .lap(s_lap), .lap_min(s_lap_min), .lap_sec(s_lap_sec), .lap_valid(s_lap_valid)
`endif
    );

    // Seconds counter model for the main instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_value <= 6'd0; sec_rollover <= 1'b0;
        end else if (sec_clr) begin
            sec_value <= 6'd0; sec_rollover <= 1'b0;
        end else if (sec_en) begin
            if (sec_value == 6'd59) begin
                sec_value <= 6'd0; sec_rollover <= 1'b1;
            end else begin
                sec_value <= sec_value + 6'd1; sec_rollover <= 1'b0;
            end
        end else begin
            sec_rollover <= 1'b0;
        end
    end

    // Seconds counter model for the saturation instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sec_value <= 6'd0; s_sec_rollover <= 1'b0;
        end else if (s_sec_clr) begin
            s_sec_value <= 6'd0; s_sec_rollover <= 1'b0;
        end else if (s_sec_en) begin
            if (s_sec_value == 6'd59) begin
                s_sec_value <= 6'd0; s_sec_rollover <= 1'b1;
            end else begin
                s_sec_value <= s_sec_value + 6'd1; s_sec_rollover <= 1'b0;
            end
        end else begin
            s_sec_rollover <= 1'b0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic i_start, i_stop, i_clear, i_lap;
        int   e_st, e_en, e_clr, e_lapv, e_laps;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_start, input logic a_stop, input logic a_clear,
                       input logic a_lap, input int st, input int en, input int clr,
                       input int lapv, input int laps, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.i_start = a_start; v.i_stop = a_stop; v.i_clear = a_clear; v.i_lap = a_lap;
            v.e_st = st; v.e_en = en; v.e_clr = clr; v.e_lapv = lapv; v.e_laps = laps;
            vecs.push_back(v);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int ro_edge;
        int pulses;

        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0; s_lap = 1'b0;
`endif

        // Vector table: one row per clock edge, expectations after that edge.
        //  start stop clear lap | state en clr lapv laps | repeat
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // k0 start
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);  // k1-3
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k4 tick
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k8 tick
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k12 tick
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 2, 0, 0, 0, 0, 1);  // k16 stop on tick cycle
        add(0, 0, 0, 0, 2, 0, 0, 0, 0, 3);
        add(0, 0, 0, 1, 2, 0, 0, 0, 0, 1);  // k20 lap in PAUSE ignored
        add(0, 0, 0, 0, 2, 0, 0, 0, 0, 6);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // k27 resume
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k28 held tick fires
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k32 tick
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1, 5, 1);  // k34 lap at 00:05
        add(0, 0, 0, 0, 1, 0, 0, 1, 5, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1, 5, 1);  // k36 tick
        add(0, 0, 0, 0, 1, 0, 0, 1, 5, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1, 6, 1);  // k38 lap at 00:06
        add(0, 0, 0, 0, 1, 0, 0, 1, 6, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1, 6, 1);  // k40 tick
        add(0, 0, 0, 0, 1, 0, 0, 1, 6, 1);
        add(1, 0, 1, 0, 0, 0, 1, 0, 0, 1);  // k42 clear+start at 00:07
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);  // k44 clear in IDLE
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);  // k46 stop in IDLE ignored
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // k47 start
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);  // k51 first tick after restart

        cyc(); cyc();
        check("rst_state", int'(state), 0);
        check("rst_running", int'(running), 0);
        check("rst_sec_en", int'(sec_en), 0);
        check("rst_sec_clr", int'(sec_clr), 0);
        check("rst_minutes", int'(minutes), 0);
        check("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            start = vecs[k].i_start; stop = vecs[k].i_stop; clear = vecs[k].i_clear;
`ifdef STOPWATCH_LAP_EN
            lap = vecs[k].i_lap;
`endif
            cyc();
            check($sformatf("k%0d_state", k), int'(state), vecs[k].e_st);
            check($sformatf("k%0d_running", k), int'(running), (vecs[k].e_st == 1) ? 1 : 0);
            check($sformatf("k%0d_sec_en", k), int'(sec_en), vecs[k].e_en);
            check($sformatf("k%0d_sec_clr", k), int'(sec_clr), vecs[k].e_clr);
            check($sformatf("k%0d_minutes", k), int'(minutes), 0);
            check($sformatf("k%0d_overflow", k), int'(overflow), 0);
`ifdef STOPWATCH_LAP_EN
            check($sformatf("k%0d_lap_valid", k), int'(lap_valid), vecs[k].e_lapv);
            check($sformatf("k%0d_lap_sec", k), int'(lap_sec), vecs[k].e_laps);
            check($sformatf("k%0d_lap_min", k), int'(lap_min), 0);
`endif
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif

        // 60 ticks from a clean start: rollover, then minutes=1 one edge later.
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        ro_edge = -1;
        for (int e = 1; e <= 400; e++) begin
            cyc();
            if (sec_rollover) begin
                ro_edge = e;
                break;
            end
        end
        check("rollover_edge", ro_edge, 241);
        check("rollover_sec_value", int'(sec_value), 0);
        check("rollover_minutes_before", int'(minutes), 0);
        cyc();
        check("minutes_after_rollover", int'(minutes), 1);
        check("minutes_state_run", int'(state), 1);

        // Saturation with MAX_MIN=1: DONE replaces the tick after 01:59.
        s_start = 1'b1; cyc(); s_start = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 480; e++) begin
            cyc();
            if (s_sec_en) pulses++;
            if (e == 479) begin
                check("sat_pre_state", int'(s_state), 1);
                check("sat_pre_minutes", int'(s_minutes), 1);
                check("sat_pre_sec", int'(s_sec_value), 59);
                check("sat_pre_overflow", int'(s_overflow), 0);
            end
            if (e == 480) begin
                check("sat_state", int'(s_state), 3);
                check("sat_overflow", int'(s_overflow), 1);
                check("sat_sec_en", int'(s_sec_en), 0);
                check("sat_running", int'(s_running), 0);
            end
        end
        check("sat_pulse_count", pulses, 119);
        s_start = 1'b1; cyc(); s_start = 1'b0;
        check("done_start_ignored", int'(s_state), 3);
        check("done_no_sec_en", int'(s_sec_en), 0);
        s_stop = 1'b1; cyc(); s_stop = 1'b0;
        check("done_stop_ignored", int'(s_state), 3);
        check("done_minutes_held", int'(s_minutes), 1);
        s_clear = 1'b1; cyc(); s_clear = 1'b0;
        check("done_clear_state", int'(s_state), 0);
        check("done_clear_overflow", int'(s_overflow), 0);
        check("done_clear_minutes", int'(s_minutes), 0);
        check("done_clear_sec_clr", int'(s_sec_clr), 1);
        cyc();
        check("done_clear_sec_clr_end", int'(s_sec_clr), 0);

        // Asynchronous reset between clock edges while running.
        #2 rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_minutes", int'(minutes), 0);
        check("async_running", int'(running), 0);
        check("async_sec_clr", int'(sec_clr), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_reset_state", int'(state), 0);
        check("post_reset_sec_clr", int'(sec_clr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. Derives a one-second tick from the system clock and runs an IDLE/RUN/PAUSE/DONE state machine from debounced start/stop/clear pulses. It gates the seconds counter's `enable`, owns the minutes count (driven by the seconds counter's `rollover`) and saturates the display at MAX_MIN:59. It sits between the button conditioning logic and the seconds counter / display driver.

## Interface
- `CLK_DIV`, default 100_000_000: clock cycles per second tick; must be ≥ 2.
- `MAX_MIN`, default 99: highest minutes value; must be ≤ 127.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse, start/resume.
- `stop` in 1: single-cycle pulse, pause.
- `clear` in 1: single-cycle pulse, return to 00:00 and IDLE.
- `sec_rollover` in 1: seconds counter wrap pulse (59→0).
- `sec_value` in 6: current seconds count.
- `sec_en` out 1: one-cycle enable to the seconds counter.
- `sec_clr` out 1: one-cycle synchronous clear request to the seconds counter.
- `minutes` out 7: minutes count, 0..MAX_MIN.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `running` out 1: high while in RUN.
- `overflow` out 1: sticky; set on entry to DONE.

## Operation
- Reset values: state=IDLE; prescaler=0; all outputs 0.
- Prescaler counts 0..CLK_DIV-1 only in RUN and wraps to 0.
  - Holds its value in PAUSE, so the sub-second fraction is preserved across a pause.
  - Forced to 0 by clear and by IDLE→RUN.
- Tick condition: state=RUN and prescaler=CLK_DIV-1.
  - On a tick, `sec_en` is registered high for exactly one cycle.
  - Exception: if a saturation tick is pending (minutes=MAX_MIN and sec_value=59), `sec_en` is not issued. Instead state→DONE and overflow←1.
- Minutes: +1 on the edge where `sec_rollover`=1.
  - Never exceeds MAX_MIN. A rollover arriving at MAX_MIN is ignored.
- State transitions:
  - IDLE: start→RUN.
  - RUN: stop→PAUSE; saturation→DONE.
  - PAUSE: start→RUN.
  - DONE: start and stop are ignored.
  - Any state: clear→IDLE.
- Ignored pulses: start in RUN or DONE; stop in IDLE, PAUSE or DONE.
- Priority for the same cycle: clear > stop > start > tick.
  - stop on a tick cycle: the tick is suppressed and the prescaler holds at CLK_DIV-1, so the tick fires on the first RUN cycle after resume.
- clear: minutes←0, prescaler←0, overflow←0, state←IDLE, and `sec_clr` is registered high for one cycle.
  - clear in IDLE still pulses `sec_clr`.
- `running` = (state==RUN), registered alongside state.

## Timing
- All outputs are registered. Every state, count and output change is visible one cycle after the sampling edge.
- Start-to-first-`sec_en`: a start pulse sampled at edge 0 gives state=RUN after edge 0 and `sec_en` high after edge CLK_DIV.
- `sec_en` period in uninterrupted RUN: exactly CLK_DIV cycles.
- Minutes updates one edge after `sec_rollover` is sampled high.
- Saturation: the DONE entry edge is the edge that would have raised `sec_en`.
- `rst_n` asserted mid-operation: immediate asynchronous return to reset values, independent of the clock. No `sec_clr` pulse is produced; the seconds counter shares `rst_n`.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - Adds input `lap` (single-cycle pulse), outputs `lap_min`[6:0], `lap_sec`[5:0], `lap_valid`.
  - `lap` sampled in RUN captures {minutes, sec_value} the next cycle and sets `lap_valid`=1.
  - `lap` in other states is ignored.
  - clear and reset zero all three lap outputs.
- Not defined: these ports and registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package `stopwatch_pkg` holds:
  - state enum `sw_state_t` (IDLE/RUN/PAUSE/DONE encodings);
  - `SEC_MAX`=59;
  - width constants: seconds 6, minutes 7.
- Sub-module `tick_gen`: the prescaler, with inputs run/hold/zero and a terminal-count output. The FSM, minutes counter and lap logic stay in `stopwatch_ctrl`.

## Test plan
All scenarios use CLK_DIV=4 and a seconds counter model attached.
- Reset, then start at cycle 0 → `sec_en` at cycles 4, 8, 12, ..., each one cycle wide; `running`=1, state=1.
- Run 60 ticks → `sec_rollover` pulse, then minutes=1 one cycle later and sec_value=0.
- stop on a tick cycle, wait 10 cycles, then start → no `sec_en` during PAUSE, and `sec_en` on the first cycle after resume.
- MAX_MIN=1, run to 01:59 → at the next tick state=DONE, `overflow`=1, no `sec_en`; a later start is ignored.
- clear and start in the same cycle while in RUN at 00:07 → state=IDLE, minutes=0, `sec_clr` one cycle, `overflow`=0.
- With `STOPWATCH_LAP_EN`: lap at 00:05 → `lap_sec`=5, `lap_min`=0, `lap_valid`=1; lap in PAUSE → lap outputs unchanged.
